// File: rtl/alu_pkg.sv
// Shared decode definitions for the RV32I decode stage and the ALU.
// Contents:
//   alu_op_t     - ALU opcode encoding shared with the alu block
//   OPC_*        - RV32I major opcodes recognised by the decoder
//   A_SEL_*      - operand A select encodings
//   decode_t     - every decode field presented on the out_* side
//   funct3AluOp  - default ALU op for an OP/OP-IMM funct3
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_EQ   = 4'd10
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_PC   = 2'd1;
    localparam logic [1:0] A_SEL_ZERO = 2'd2;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [1:0]  a_sel;
        logic        b_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        br_inv;
        logic        illegal;
    } decode_t;

    // funct3 to ALU op for register and immediate arithmetic; the
    // SUB/SRA variants are picked by the caller from funct7.
    function automatic alu_op_t funct3AluOp(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Handshake bundle around the decode stage.
//   in_*  : fetch side, instruction word + pc with valid/ready
//   out_* : execute side, registered decode fields with valid/ready
// Modports:
//   slave  - the decode stage itself
//   master - the environment feeding instructions and consuming results
interface alu_decode_stage_if;

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [31:0]           in_pc;

    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_pc;
    alu_pkg::alu_op_t      out_alu_op;
    logic [1:0]            out_a_sel;
    logic                  out_b_imm;
    logic [31:0]           out_imm;
    logic [4:0]            out_rs1;
    logic [4:0]            out_rs2;
    logic [4:0]            out_rd;
    logic                  out_reg_we;
    logic                  out_mem_rd;
    logic                  out_mem_wr;
    logic                  out_branch;
    logic                  out_jump;
    logic                  out_br_inv;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_op, out_a_sel, out_b_imm,
               out_imm, out_rs1, out_rs2, out_rd, out_reg_we, out_mem_rd,
               out_mem_wr, out_branch, out_jump, out_br_inv, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_op, out_a_sel, out_b_imm,
               out_imm, out_rs1, out_rs2, out_rd, out_reg_we, out_mem_rd,
               out_mem_wr, out_branch, out_jump, out_br_inv, out_illegal
    );

endinterface

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I decoder.
// Ports:
//   instr_i - 32-bit instruction word
//   dec_o   - decoded ALU/operand/control fields including the immediate
module rv32i_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output decode_t     dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immI, immS, immB, immU, immJ;
    decode_t     raw;
    logic        bad;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign immI = {{20{instr_i[31]}}, instr_i[31:20]};
    assign immS = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign immB = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign immU = {instr_i[31:12], 12'b0};
    assign immJ = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Per-opcode field selection; anything not recognised raises bad.
    always_comb begin
        raw        = '0;
        raw.alu_op = ALU_ADD;
        raw.a_sel  = A_SEL_RS1;
        raw.rs1    = instr_i[19:15];
        raw.rs2    = instr_i[24:20];
        raw.rd     = instr_i[11:7];
        bad        = 1'b0;
        case (opcode)
            OPC_OP: begin
                raw.reg_we = 1'b1;
                raw.alu_op = funct3AluOp(funct3);
                // The alternate funct7 only exists for SUB and SRA.
                if (funct7 == 7'b0100000 && funct3 == 3'd0)
                    raw.alu_op = ALU_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'd5)
                    raw.alu_op = ALU_SRA;
                else if (funct7 != 7'b0)
                    bad = 1'b1;
            end
            OPC_OPIMM: begin
                raw.reg_we = 1'b1;
                raw.b_imm  = 1'b1;
                raw.imm    = immI;
                raw.alu_op = funct3AluOp(funct3);
                // Only the shift-immediates reserve the upper bits as funct7.
                if (funct3 == 3'd1 && funct7 != 7'b0)
                    bad = 1'b1;
                if (funct3 == 3'd5) begin
                    if (funct7 == 7'b0100000)
                        raw.alu_op = ALU_SRA;
                    else if (funct7 != 7'b0)
                        bad = 1'b1;
                end
            end
            OPC_LUI: begin
                raw.reg_we = 1'b1;
                raw.b_imm  = 1'b1;
                raw.a_sel  = A_SEL_ZERO;
                raw.imm    = immU;
            end
            OPC_AUIPC: begin
                raw.reg_we = 1'b1;
                raw.b_imm  = 1'b1;
                raw.a_sel  = A_SEL_PC;
                raw.imm    = immU;
            end
            OPC_LOAD: begin
                raw.reg_we = 1'b1;
                raw.mem_rd = 1'b1;
                raw.b_imm  = 1'b1;
                raw.imm    = immI;
                bad        = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                raw.mem_wr = 1'b1;
                raw.b_imm  = 1'b1;
                raw.imm    = immS;
                bad        = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                raw.branch = 1'b1;
                raw.imm    = immB;
                // funct3[0] is the "negate the comparison" bit.
                raw.br_inv = funct3[0];
                case (funct3[2:1])
                    2'b00:   raw.alu_op = ALU_EQ;
                    2'b10:   raw.alu_op = ALU_SLT;
                    2'b11:   raw.alu_op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                raw.jump   = 1'b1;
                raw.reg_we = 1'b1;
                raw.b_imm  = 1'b1;
                raw.a_sel  = A_SEL_PC;
                raw.imm    = immJ;
            end
            OPC_JALR: begin
                raw.jump   = 1'b1;
                raw.reg_we = 1'b1;
                raw.b_imm  = 1'b1;
                raw.imm    = immI;
                bad        = (funct3 != 3'd0);
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal words keep only the raw register indices; rd is squashed
    // whenever nothing gets written back.
    always_comb begin
        dec_o = raw;
        if (bad) begin
            dec_o         = '0;
            dec_o.rs1     = raw.rs1;
            dec_o.rs2     = raw.rs2;
            dec_o.illegal = 1'b1;
        end
        if (!dec_o.reg_we)
            dec_o.rd = '0;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode pipeline stage with a two-entry skid buffer.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   flush - drop every held and incoming instruction
//   bus   - slave side of alu_decode_stage_if (instruction in, decode out)
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [31:0] pc;
        decode_t     dec;
    } entry_t;

    decode_t decoded;
    entry_t  incoming;
    entry_t  main_q, main_d, skid_q, skid_d;
    logic    mainValid_q, mainValid_d;
    logic    skidValid_q, skidValid_d;
    logic    inReady_q, inReady_d;
    logic    inFire, outFire;

    rv32i_decoder u_decoder (
        .instr_i (bus.in_instr),
        .dec_o   (decoded)
    );

    assign incoming = {bus.in_pc, decoded};
    assign inFire   = bus.in_valid & inReady_q;
    assign outFire  = mainValid_q & bus.out_ready;

    // Main always feeds the outputs. When main frees up, the oldest held
    // entry (skid) refills it before any new word; a new word only lands
    // in skid when main is occupied and not draining.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (!mainValid_q || outFire) begin
            if (skidValid_q) begin
                main_d      = skid_q;
                mainValid_d = 1'b1;
                skidValid_d = inFire;
                if (inFire)
                    skid_d = incoming;
            end else begin
                mainValid_d = inFire;
                if (inFire)
                    main_d = incoming;
            end
        end else if (inFire) begin
            skid_d      = incoming;
            skidValid_d = 1'b1;
        end
        // Registered ready: accept next cycle only if skid will be free.
        inReady_d = !skidValid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            inReady_q   <= 1'b1;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            inReady_q   <= inReady_d;
        end
    end

    assign bus.in_ready    = inReady_q;
    assign bus.out_valid   = mainValid_q;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_alu_op  = main_q.dec.alu_op;
    assign bus.out_a_sel   = main_q.dec.a_sel;
    assign bus.out_b_imm   = main_q.dec.b_imm;
    assign bus.out_imm     = main_q.dec.imm;
    assign bus.out_rs1     = main_q.dec.rs1;
    assign bus.out_rs2     = main_q.dec.rs2;
    assign bus.out_rd      = main_q.dec.rd;
    assign bus.out_reg_we  = main_q.dec.reg_we;
    assign bus.out_mem_rd  = main_q.dec.mem_rd;
    assign bus.out_mem_wr  = main_q.dec.mem_wr;
    assign bus.out_branch  = main_q.dec.branch;
    assign bus.out_jump    = main_q.dec.jump;
    assign bus.out_br_inv  = main_q.dec.br_inv;
    assign bus.out_illegal = main_q.dec.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: directed instruction words, a
// mnemonic-level reference decoder and an in-order expectation queue.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  aluOp;
        logic [1:0]  aSel;
        logic        bImm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regWe;
        logic        memRd;
        logic        memWr;
        logic        branch;
        logic        jump;
        logic        brInv;
        logic        illegal;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    expect_t pending[$];

    alu_decode_stage_if bus();

    alu_decode_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference decoder: names the instruction, then fills in the fields
    // that instruction needs; immediates come from signed integer shifts.
    function automatic expect_t model(input logic [31:0] w, input logic [31:0] pc);
        expect_t e;
        int      s;
        logic    ok;
        logic [2:0] f3;
        logic [6:0] f7;
        s  = int'(w);
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1'b1;
        e  = '0;
        e.pc  = pc;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        case (w[6:0])
            7'h33: begin
                e.regWe = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: e.aluOp = 4'd0;
                    {7'h20, 3'd0}: e.aluOp = 4'd1;
                    {7'h00, 3'd1}: e.aluOp = 4'd5;
                    {7'h00, 3'd2}: e.aluOp = 4'd8;
                    {7'h00, 3'd3}: e.aluOp = 4'd9;
                    {7'h00, 3'd4}: e.aluOp = 4'd4;
                    {7'h00, 3'd5}: e.aluOp = 4'd6;
                    {7'h20, 3'd5}: e.aluOp = 4'd7;
                    {7'h00, 3'd6}: e.aluOp = 4'd3;
                    {7'h00, 3'd7}: e.aluOp = 4'd2;
                    default:       ok = 1'b0;
                endcase
            end
            7'h13: begin
                e.regWe = 1'b1;
                e.bImm  = 1'b1;
                e.imm   = 32'(s >>> 20);
                case (f3)
                    3'd0: e.aluOp = 4'd0;
                    3'd2: e.aluOp = 4'd8;
                    3'd3: e.aluOp = 4'd9;
                    3'd4: e.aluOp = 4'd4;
                    3'd6: e.aluOp = 4'd3;
                    3'd7: e.aluOp = 4'd2;
                    3'd1: begin e.aluOp = 4'd5; ok = (f7 == 7'h00); end
                    default: begin
                        if (f7 == 7'h00)      e.aluOp = 4'd6;
                        else if (f7 == 7'h20) e.aluOp = 4'd7;
                        else                  ok = 1'b0;
                    end
                endcase
            end
            7'h37: begin e.regWe = 1'b1; e.bImm = 1'b1; e.aSel = 2'd2; e.imm = w & 32'hFFFFF000; end
            7'h17: begin e.regWe = 1'b1; e.bImm = 1'b1; e.aSel = 2'd1; e.imm = w & 32'hFFFFF000; end
            7'h03: begin
                e.regWe = 1'b1; e.memRd = 1'b1; e.bImm = 1'b1;
                e.imm   = 32'(s >>> 20);
                ok      = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
            end
            7'h23: begin
                e.memWr = 1'b1; e.bImm = 1'b1;
                e.imm   = 32'((s >>> 25) << 5) | {27'b0, w[11:7]};
                ok      = (f3 <= 3'd2);
            end
            7'h63: begin
                e.branch = 1'b1;
                e.imm    = 32'((s >>> 31) << 12) | {20'b0, w[7], w[30:25], w[11:8], 1'b0};
                case (f3)
                    3'd0: e.aluOp = 4'd10;
                    3'd1: begin e.aluOp = 4'd10; e.brInv = 1'b1; end
                    3'd4: e.aluOp = 4'd8;
                    3'd5: begin e.aluOp = 4'd8; e.brInv = 1'b1; end
                    3'd6: e.aluOp = 4'd9;
                    3'd7: begin e.aluOp = 4'd9; e.brInv = 1'b1; end
                    default: ok = 1'b0;
                endcase
            end
            7'h6F: begin
                e.jump = 1'b1; e.regWe = 1'b1; e.bImm = 1'b1; e.aSel = 2'd1;
                e.imm  = 32'((s >>> 31) << 20) | {12'b0, w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin
                e.jump = 1'b1; e.regWe = 1'b1; e.bImm = 1'b1;
                e.imm  = 32'(s >>> 20);
                ok     = (f3 == 3'd0);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e         = '0;
            e.pc      = pc;
            e.rs1     = w[19:15];
            e.rs2     = w[24:20];
            e.illegal = 1'b1;
        end
        e.rd = e.regWe ? w[11:7] : 5'd0;
        return e;
    endfunction

    // DUT outputs packed in the same field order as expect_t.
    function automatic logic [127:0] dutFields();
        return 128'({bus.out_pc, 4'(bus.out_alu_op), bus.out_a_sel, bus.out_b_imm, bus.out_imm,
                     bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_reg_we, bus.out_mem_rd,
                     bus.out_mem_wr, bus.out_branch, bus.out_jump, bus.out_br_inv, bus.out_illegal});
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then step to just after the next edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    // Every cycle: valid/ready must match queue occupancy and the head of
    // the queue must be what the stage presents; then account for this
    // cycle's handshakes.
    always @(negedge clk) begin
        if (rst) begin
            pending.delete();
        end else begin
            checkOutput("out_valid", 128'(bus.out_valid), 128'(pending.size() != 0));
            checkOutput("in_ready", 128'(bus.in_ready), 128'(pending.size() < 2));
            if (bus.out_valid && pending.size() != 0)
                checkOutput("decode", dutFields(), 128'(pending[0]));
            if (flush) begin
                pending.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && pending.size() != 0)
                    void'(pending.pop_front());
                if (bus.in_valid && bus.in_ready)
                    pending.push_back(model(bus.in_instr, bus.in_pc));
            end
        end
    end

    localparam logic [31:0] ADDI  = 32'h00510093;
    localparam logic [31:0] SUB   = 32'h402081B3;
    localparam logic [31:0] SRAI  = 32'h40335293;
    localparam logic [31:0] BNE   = 32'h00209463;
    localparam logic [31:0] LUI   = 32'h123450B7;
    localparam logic [31:0] ONES  = 32'hFFFFFFFF;

    logic [31:0] prog [14] = '{32'h00510093, 32'h402081B3, 32'hFFC12283, 32'h0060A423,
                                32'h010000EF, 32'h00008067, 32'h00001197, 32'hFE62FEE3,
                                32'h02208033, 32'h0000B003, 32'h40109093, 32'hFFF3E393,
                                32'h0000000F, 32'h40335293};

    initial begin
        expect_t m;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        // Pin the reference decoder with hand-decoded words.
        m = model(ADDI, 32'h0);
        checkOutput("pin_addi", 128'({m.aluOp, m.bImm, m.imm, m.rs1, m.rd, m.regWe}),
                    128'({4'd0, 1'b1, 32'd5, 5'd2, 5'd1, 1'b1}));
        m = model(SUB, 32'h0);
        checkOutput("pin_sub", 128'({m.aluOp, m.bImm, m.rd}), 128'({4'd1, 1'b0, 5'd3}));
        m = model(SRAI, 32'h0);
        checkOutput("pin_srai", 128'({m.aluOp, m.imm[4:0], m.rd}), 128'({4'd7, 5'd3, 5'd5}));
        m = model(BNE, 32'h0);
        checkOutput("pin_bne", 128'({m.aluOp, m.brInv, m.branch, m.imm, m.regWe, m.rd}),
                    128'({4'd10, 1'b1, 1'b1, 32'd8, 1'b0, 5'd0}));
        m = model(LUI, 32'h0);
        checkOutput("pin_lui", 128'({m.aluOp, m.aSel, m.imm}), 128'({4'd0, 2'd2, 32'h12345000}));
        m = model(ONES, 32'h0);
        checkOutput("pin_illegal", 128'({m.illegal, m.regWe, m.memRd, m.memWr, m.branch, m.jump, m.aluOp}),
                    128'({1'b1, 5'b0, 4'd0}));
        m = model(32'hFFC12283, 32'h0);
        checkOutput("pin_lw", 128'({m.imm, m.memRd, m.rd}), 128'({32'hFFFFFFFC, 1'b1, 5'd5}));

        // Reset values.
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("rst_valid_ready", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
        checkOutput("rst_fields", dutFields(), 128'(0));

        // Single ADDI with one-cycle latency.
        applyStimulus(1'b1, ADDI, 32'h100, 1'b1, 1'b0);
        checkOutput("addi_valid", 128'(bus.out_valid), 128'(1));
        checkOutput("addi_fields", 128'({4'(bus.out_alu_op), bus.out_b_imm, bus.out_imm, bus.out_rs1, bus.out_rd, bus.out_reg_we}),
                    128'({4'd0, 1'b1, 32'd5, 5'd2, 5'd1, 1'b1}));

        // Back-to-back SUB then SRAI, no bubble.
        applyStimulus(1'b1, SUB, 32'h104, 1'b1, 1'b0);
        checkOutput("sub_fields", 128'({bus.out_valid, 4'(bus.out_alu_op), bus.out_b_imm, bus.out_rd}),
                    128'({1'b1, 4'd1, 1'b0, 5'd3}));
        applyStimulus(1'b1, SRAI, 32'h108, 1'b1, 1'b0);
        checkOutput("srai_fields", 128'({bus.out_valid, 4'(bus.out_alu_op), bus.out_imm[4:0], bus.out_rd}),
                    128'({1'b1, 4'd7, 5'd3, 5'd5}));
        applyStimulus(1'b1, BNE, 32'h10C, 1'b1, 1'b0);
        checkOutput("bne_fields", 128'({4'(bus.out_alu_op), bus.out_br_inv, bus.out_branch, bus.out_imm, bus.out_reg_we, bus.out_rd}),
                    128'({4'd10, 1'b1, 1'b1, 32'd8, 1'b0, 5'd0}));
        applyStimulus(1'b1, LUI, 32'h110, 1'b1, 1'b0);
        checkOutput("lui_fields", 128'({4'(bus.out_alu_op), bus.out_a_sel, bus.out_imm}),
                    128'({4'd0, 2'd2, 32'h12345000}));
        applyStimulus(1'b1, ONES, 32'h114, 1'b1, 1'b0);
        checkOutput("ones_fields", 128'({bus.out_illegal, bus.out_reg_we, bus.out_mem_rd, bus.out_mem_wr, bus.out_branch, bus.out_jump, 4'(bus.out_alu_op)}),
                    128'({1'b1, 5'b0, 4'd0}));
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Instruction stream under an irregular out_ready pattern.
        begin
            int idx = 0;
            int cyc = 0;
            logic taken;
            while (idx < 14 && cyc < 200) begin
                bus.in_valid  = 1'b1;
                bus.in_instr  = prog[idx];
                bus.in_pc     = 32'h200 + 32'(idx * 4);
                bus.out_ready = (cyc % 3) != 2;
                taken         = bus.in_ready;
                @(posedge clk);
                #1;
                if (taken)
                    idx++;
                cyc++;
            end
            if (idx < 14) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL stream_timeout: accepted %0d of 14 words", idx);
            end
        end
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: two accepted, third waits, then all drain in order.
        applyStimulus(1'b1, ADDI, 32'h300, 1'b0, 1'b0);
        checkOutput("bp_ready_after_first", 128'(bus.in_ready), 128'(1));
        applyStimulus(1'b1, SUB, 32'h304, 1'b0, 1'b0);
        checkOutput("bp_ready_after_second", 128'(bus.in_ready), 128'(0));
        applyStimulus(1'b1, LUI, 32'h308, 1'b0, 1'b0);
        checkOutput("bp_stalled", 128'({bus.in_ready, bus.out_pc}), 128'({1'b0, 32'h300}));
        applyStimulus(1'b1, LUI, 32'h308, 1'b1, 1'b0);
        checkOutput("bp_release1", 128'({bus.in_ready, bus.out_pc}), 128'({1'b1, 32'h304}));
        applyStimulus(1'b1, LUI, 32'h308, 1'b1, 1'b0);
        checkOutput("bp_release2", 128'({bus.out_valid, bus.out_pc}), 128'({1'b1, 32'h308}));
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("bp_empty", 128'(bus.out_valid), 128'(0));

        // Flush with both entries full and a word offered.
        applyStimulus(1'b1, ADDI, 32'h400, 1'b0, 1'b0);
        applyStimulus(1'b1, SUB, 32'h404, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100113, 32'h408, 1'b0, 1'b1);
        checkOutput("flush_valid", 128'(bus.out_valid), 128'(0));
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("flush_ready", 128'({bus.in_ready, bus.out_valid}), 128'(2'b10));

        // Flush while a handshake completes: the word is discarded.
        applyStimulus(1'b1, ADDI, 32'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, LUI, 32'h504, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("flush_discard", 128'(bus.out_valid), 128'(0));

        // Reset in the middle of traffic.
        applyStimulus(1'b1, ADDI, 32'h600, 1'b0, 1'b0);
        applyStimulus(1'b1, BNE, 32'h604, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midrst_valid_ready", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
        checkOutput("midrst_fields", dutFields(), 128'(0));
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
